and_tree_param: RTL and testbench



---
 rtl/and_tree_param_if.sv | 53 +++++
 rtl/and_tree_param.sv | 219 +++++++++++++++++++++
 tb/tb_and_tree_param.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/and_tree_param_if.sv
// Bundle of search / result / update / summary signals between the FDT and
// the AND-tree leaf level. The leaf level uses the slave modport.
interface and_tree_param_if #(
    parameter int NUM_CLASS = 4,
    parameter int ROW_BITS  = 64,
    parameter int ROW_IDX_W = 6,
    parameter int ID_W      = 4
);
    localparam int CLASS_W = $clog2(NUM_CLASS);
    localparam int COL_W   = $clog2(ROW_BITS);
    localparam int LEAF_W  = ROW_IDX_W + COL_W;

    // search request
    logic                 srch_valid;
    logic                 srch_ready;
    logic [ID_W-1:0]      srch_id;
    logic [CLASS_W-1:0]   srch_class;
    logic [ROW_IDX_W-1:0] srch_row;
    // search result
    logic                 res_valid;
    logic [ID_W-1:0]      res_id;
    logic [CLASS_W-1:0]   res_class;
    logic                 res_found;
    logic [LEAF_W-1:0]    res_idx;
    // bit update
    logic                 upd_valid;
    logic                 upd_ready;
    logic [ROW_IDX_W-1:0] upd_row;
    logic [COL_W-1:0]     upd_col;
    logic [NUM_CLASS-1:0] upd_bits;
    // row summary
    logic                 sum_valid;
    logic [ROW_IDX_W-1:0] sum_row;
    logic [NUM_CLASS-1:0] sum_bits;
    // status
    logic                 init_done;

    modport master (
        output srch_valid, srch_id, srch_class, srch_row,
        output upd_valid, upd_row, upd_col, upd_bits,
        input  srch_ready, upd_ready, init_done,
        input  res_valid, res_id, res_class, res_found, res_idx,
        input  sum_valid, sum_row, sum_bits
    );

    modport slave (
        input  srch_valid, srch_id, srch_class, srch_row,
        input  upd_valid, upd_row, upd_col, upd_bits,
        output srch_ready, upd_ready, init_done,
        output res_valid, res_id, res_class, res_found, res_idx,
        output sum_valid, sum_row, sum_bits
    );
endinterface

// File: rtl/and_tree_param.sv
// AND-tree leaf level: per-class bitmaps (1 = used), lowest-free-leaf search
// and forwarded read-modify-write bit updates with per-row AND summaries.
module and_tree_param #(
    parameter int NUM_CLASS = 4,
    parameter int ROW_BITS  = 64,
    parameter int ROW_IDX_W = 6,
    parameter int ID_W      = 4
) (
    input logic           clk,
    input logic           rst_n,
    and_tree_param_if.slave bus
);
    localparam int CLASS_W = $clog2(NUM_CLASS);
    localparam int COL_W   = $clog2(ROW_BITS);
    localparam int LEAF_W  = ROW_IDX_W + COL_W;
    localparam int ROWS    = 1 << ROW_IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [ROW_IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic                 init_wr;
    logic                 run;

    logic srch_acc, upd_acc;

    // search pipeline
    logic                 s1_valid_q, s2_valid_q;
    logic [ID_W-1:0]      s1_id_q, s2_id_q;
    logic [CLASS_W-1:0]   s1_class_q, s2_class_q;
    logic [ROW_IDX_W-1:0] s1_row_q, s2_row_q;
    logic [ROW_BITS-1:0]  s2_data_q;
    logic [NUM_CLASS-1:0][ROW_BITS-1:0] srch_rd;

    // update pipeline
    logic                 u1_valid_q, u2_valid_q;
    logic [ROW_IDX_W-1:0] u1_row_q, u2_row_q;
    logic [COL_W-1:0]     u1_col_q, u2_col_q;
    logic [NUM_CLASS-1:0] u1_bits_q, u2_bits_q;
    logic [NUM_CLASS-1:0] mod_and;

    // outputs
    logic                 res_valid_q, res_found_q;
    logic [ID_W-1:0]      res_id_q;
    logic [CLASS_W-1:0]   res_class_q;
    logic [LEAF_W-1:0]    res_idx_q;
    logic                 sum_valid_q;
    logic [ROW_IDX_W-1:0] sum_row_q;
    logic [NUM_CLASS-1:0] sum_bits_q;

    logic [COL_W-1:0]     pe_col;
    logic                 pe_found;

    // FSM state and init row counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // FSM next state: clear one row per cycle, then run
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ROW_IDX_W'(ROWS - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // FSM outputs decoded from the state flop
    always_comb begin
        init_wr = (state_q == ST_INIT);
        run     = (state_q == ST_RUN);
    end

    assign srch_acc = bus.srch_valid & run;
    assign upd_acc  = bus.upd_valid & run;

    // Per-class storage, forwarded reads and the modified row
    for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_class
        logic [ROW_BITS-1:0] mem_q [ROWS];
        logic [ROW_BITS-1:0] u2_data_q;
        logic [ROW_BITS-1:0] mod_row;

        // single write port: init clear or update write-back
        always_ff @(posedge clk) begin
            if (init_wr) begin
                mem_q[init_cnt_q] <= '0;
            end else if (u2_valid_q) begin
                mem_q[u2_row_q] <= mod_row;
            end
        end

        // update read stage, merging the write-back happening this same edge
        always_ff @(posedge clk) begin
            if (u1_valid_q) begin
                u2_data_q <= (u2_valid_q && (u2_row_q == u1_row_q)) ? mod_row
                                                                    : mem_q[u1_row_q];
            end
        end

        // apply this class's new bit value to the read row
        always_comb begin
            mod_row           = u2_data_q;
            mod_row[u2_col_q] = u2_bits_q[gi];
        end

        assign mod_and[gi] = &mod_row;
        assign srch_rd[gi] = (u2_valid_q && (u2_row_q == s1_row_q)) ? mod_row
                                                                    : mem_q[s1_row_q];
    end

    // lowest zero column, LSB first; col 0 when the row is full
    always_comb begin
        pe_col   = '0;
        pe_found = 1'b0;
        for (int i = ROW_BITS - 1; i >= 0; i--) begin
            if (!s2_data_q[i]) begin
                pe_col   = COL_W'(i);
                pe_found = 1'b1;
            end
        end
    end

    // search pipeline: accept, read, result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_class_q  <= '0;
            s1_row_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_class_q  <= '0;
            s2_row_q    <= '0;
            s2_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_class_q <= '0;
            res_found_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            s1_valid_q <= srch_acc;
            if (srch_acc) begin
                s1_id_q    <= bus.srch_id;
                s1_class_q <= bus.srch_class;
                s1_row_q   <= bus.srch_row;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_id_q    <= s1_id_q;
                s2_class_q <= s1_class_q;
                s2_row_q   <= s1_row_q;
                s2_data_q  <= srch_rd[s1_class_q];
            end
            res_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                res_id_q    <= s2_id_q;
                res_class_q <= s2_class_q;
                res_found_q <= pe_found;
                res_idx_q   <= {s2_row_q, pe_col};
            end
        end
    end

    // update pipeline: accept, read, write-back with summary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u1_valid_q  <= 1'b0;
            u1_row_q    <= '0;
            u1_col_q    <= '0;
            u1_bits_q   <= '0;
            u2_valid_q  <= 1'b0;
            u2_row_q    <= '0;
            u2_col_q    <= '0;
            u2_bits_q   <= '0;
            sum_valid_q <= 1'b0;
            sum_row_q   <= '0;
            sum_bits_q  <= '0;
        end else begin
            u1_valid_q <= upd_acc;
            if (upd_acc) begin
                u1_row_q  <= bus.upd_row;
                u1_col_q  <= bus.upd_col;
                u1_bits_q <= bus.upd_bits;
            end
            u2_valid_q <= u1_valid_q;
            if (u1_valid_q) begin
                u2_row_q  <= u1_row_q;
                u2_col_q  <= u1_col_q;
                u2_bits_q <= u1_bits_q;
            end
            sum_valid_q <= u2_valid_q;
            if (u2_valid_q) begin
                sum_row_q  <= u2_row_q;
                sum_bits_q <= mod_and;
            end
        end
    end

    assign bus.srch_ready = run;
    assign bus.upd_ready  = run;
    assign bus.init_done  = run;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_class  = res_class_q;
    assign bus.res_found  = res_found_q;
    assign bus.res_idx    = res_idx_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.sum_row    = sum_row_q;
    assign bus.sum_bits   = sum_bits_q;
endmodule

// File: tb/tb_and_tree_param.sv
// Scoreboard bench for and_tree_param: stimulus pushes expected results and
// summaries; a negedge monitor pops and compares on every output pulse.
module tb_and_tree_param;
    localparam int NUM_CLASS = 4;
    localparam int ROW_BITS  = 64;
    localparam int ROW_IDX_W = 6;
    localparam int ID_W      = 4;
    localparam int CLASS_W   = 2;
    localparam int LEAF_W    = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    and_tree_param_if #(
        .NUM_CLASS(NUM_CLASS), .ROW_BITS(ROW_BITS),
        .ROW_IDX_W(ROW_IDX_W), .ID_W(ID_W)
    ) bus ();

    and_tree_param #(
        .NUM_CLASS(NUM_CLASS), .ROW_BITS(ROW_BITS),
        .ROW_IDX_W(ROW_IDX_W), .ID_W(ID_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [CLASS_W-1:0] cls;
        logic               found;
        logic [LEAF_W-1:0]  idx;
    } res_t;

    typedef struct packed {
        logic [ROW_IDX_W-1:0] row;
        logic [NUM_CLASS-1:0] bits;
    } sum_t;

    res_t res_q[$];
    sum_t sum_q[$];
    res_t res_exp, res_act;
    sum_t sum_exp, sum_act;
    int n_tests = 0;
    int n_fail = 0;
    int res_pulses = 0;
    int sum_pulses = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compare every result / summary pulse against the scoreboard
    always @(negedge clk) begin
        if (bus.res_valid) begin
            res_pulses++;
            res_act = '{id: bus.res_id, cls: bus.res_class,
                        found: bus.res_found, idx: bus.res_idx};
            $display("[TB] res id=%0d class=%0d found=%0d idx=0x%0h",
                     bus.res_id, bus.res_class, bus.res_found, bus.res_idx);
            if (res_q.size() == 0) begin
                check("res_unexpected", 32'(res_act), 32'hFFFF_FFFF);
            end else begin
                res_exp = res_q.pop_front();
                check("res", 32'(res_act), 32'(res_exp));
            end
        end
        if (bus.sum_valid) begin
            sum_pulses++;
            sum_act = '{row: bus.sum_row, bits: bus.sum_bits};
            $display("[TB] sum row=%0d bits=%b", bus.sum_row, bus.sum_bits);
            if (sum_q.size() == 0) begin
                check("sum_unexpected", 32'(sum_act), 32'hFFFF_FFFF);
            end else begin
                sum_exp = sum_q.pop_front();
                check("sum", 32'(sum_act), 32'(sum_exp));
            end
        end
    end

    task automatic set_srch(int id, int cls, int row, bit found, int idx, bit push = 1'b1);
        res_t e;
        bus.srch_valid = 1'b1;
        bus.srch_id    = ID_W'(id);
        bus.srch_class = CLASS_W'(cls);
        bus.srch_row   = ROW_IDX_W'(row);
        e.id    = ID_W'(id);
        e.cls   = CLASS_W'(cls);
        e.found = found;
        e.idx   = LEAF_W'(idx);
        if (push) res_q.push_back(e);
    endtask

    task automatic set_upd(int row, int col, int bits, int exp_sum, bit push = 1'b1);
        sum_t e;
        bus.upd_valid = 1'b1;
        bus.upd_row   = ROW_IDX_W'(row);
        bus.upd_col   = 6'(col);
        bus.upd_bits  = NUM_CLASS'(bits);
        e.row  = ROW_IDX_W'(row);
        e.bits = NUM_CLASS'(exp_sum);
        if (push) sum_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        bus.srch_valid = 1'b0;
        bus.upd_valid  = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // count rising edges from reset release (at a negedge) until ready
    task automatic wait_init();
        int edges;
        edges = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.srch_ready) break;
        end
        check("init_edges", 32'(edges), 32'd64);
        check("init_done", 32'(bus.init_done), 32'd1);
        check("upd_ready", 32'(bus.upd_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p_res, p_sum;
        bus.srch_valid = 1'b0;
        bus.srch_id    = '0;
        bus.srch_class = '0;
        bus.srch_row   = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_row    = '0;
        bus.upd_col    = '0;
        bus.upd_bits   = '0;

        // reset state
        idle(3);
        check("rst_srch_ready", 32'(bus.srch_ready), 32'd0);
        check("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        check("rst_res_idx", 32'(bus.res_idx), 32'd0);
        check("rst_sum_bits", 32'(bus.sum_bits), 32'd0);

        // init timing
        rst_n = 1'b1;
        wait_init();

        // every row of every class starts free at column 0
        for (int c = 0; c < NUM_CLASS; c++) begin
            for (int r = 0; r < 64; r++) begin
                set_srch(r % 16, c, r, 1'b1, r * 64);
                step();
            end
        end
        idle(3);

        // fresh row search
        set_srch(3, 2, 5, 1'b1, 'h140); step();

        // three updates then immediate searches (forwarding)
        set_upd(5, 0, 'b0001, 'b0000); step();
        set_upd(5, 1, 'b0001, 'b0000); step();
        set_upd(5, 2, 'b0001, 'b0000); step();
        set_srch(1, 0, 5, 1'b1, 'h143); step();
        set_srch(2, 1, 5, 1'b1, 'h140); step();

        // fill row 9 with back-to-back updates
        for (int col = 0; col < 64; col++) begin
            set_upd(9, col, 'b1111, (col == 63) ? 'b1111 : 'b0000);
            step();
        end
        set_srch(4, 0, 9, 1'b0, 'h240); step();
        set_srch(5, 3, 9, 1'b0, 'h240); step();

        // clear one bit of the full row
        set_upd(9, 17, 'b0000, 'b0000); step();
        set_srch(6, 0, 9, 1'b1, 'h251); step();

        // same-cycle search sees pre-update data; next cycle sees the update
        set_upd(9, 17, 'b0010, 'b0010);
        set_srch(7, 1, 9, 1'b1, 'h251); step();
        set_srch(8, 1, 9, 1'b0, 'h240); step();

        // updates separated by one idle cycle compose
        set_upd(20, 0, 'b0001, 'b0000); step();
        step();
        set_upd(20, 1, 'b0001, 'b0000); step();
        set_srch(9, 0, 20, 1'b1, 'h502); step();

        idle(4);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);
        check("sum_queue_drained", 32'(sum_q.size()), 32'd0);

        // reset with a search and an update in flight
        p_res = res_pulses;
        p_sum = sum_pulses;
        set_srch(10, 2, 9, 1'b0, 0, 1'b0);
        set_upd(9, 3, 'b1111, 0, 1'b0);
        step();
        rst_n = 1'b0;
        idle(4);
        check("rst_mid_res_pulses", 32'(res_pulses), 32'(p_res));
        check("rst_mid_sum_pulses", 32'(sum_pulses), 32'(p_sum));
        check("rst_mid_ready", 32'(bus.srch_ready), 32'd0);
        rst_n = 1'b1;
        wait_init();
        check("post_rst_sum_pulses", 32'(sum_pulses), 32'(p_sum));
        set_srch(11, 0, 9, 1'b1, 'h240); step();
        set_srch(12, 3, 9, 1'b1, 'h240); step();
        idle(4);
        check("post_rst_res_pulses", 32'(res_pulses), 32'(p_res + 2));
        check("final_res_queue", 32'(res_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
